tx_cg_gen: RTL and testbench
============================

TX_CG_GEN -- requirements
Module: tx_cg_gen

Interface
REQ-001 SHALL have parameter ENABLE_CONFIG, default 1, meaning /C/ ordered sets are generated (0: /C/ requests are sent as /I/).
REQ-002 SHALL have parameter INIT_RD, default 0, meaning running disparity after reset (0 = negative, 1 = positive).
REQ-003 SHALL have port GTX_CLK  input  1  transmit clock; all state changes on its rising edge.
REQ-004 SHALL have port mr_main_reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port tx_o_set  input  3  ordered-set request: 0=/I/, 1=/C/, 2=/R/, 3=/S/, 4=/T/, 5=/V/, 6=/D/, 7=illegal.
REQ-006 SHALL have port TXD  input  8  data octet for /D/.
REQ-007 SHALL have port cfg_reg  input  16  configuration register for /C/ sets.
REQ-008 SHALL have port tx_code_group  output  10  encoded code group, bit 9 = 'a', bit 0 = 'j'.
REQ-009 SHALL have port tx_even  output  1  even/odd code-group position flag.
REQ-010 SHALL have port TX_OSET_indicate  output  1  pulse marking the last code group of the current ordered set.
REQ-011 SHALL have port tx_disparity  output  1  running disparity after the current code group (1 = positive).

Function
REQ-012 SHALL register all outputs; a tx_o_set sampled in cycle N produces its first code group in cycle N+1.
REQ-013 SHALL contain a full 8b/10b encoder (D.x.y and K28.5, K23.7, K27.7, K29.7, K30.7), selecting the RD- or RD+ encoding from the current disparity and updating it after every code group.
REQ-014 SHALL implement states GEN (ordered-set start), I_B, C_B, C_C, C_D.
REQ-015 In GEN: /I/ (or /C/ with ENABLE_CONFIG=0) -> emit K28.5, tx_even=1, next I_B; choice I1/I2 latched from disparity before K28.5 (positive -> I1, negative -> I2).
REQ-016 In I_B: emit D5.6 (I1) or D16.2 (I2), tx_even=0, TX_OSET_indicate=1, next GEN; disparity after the idle SHALL be negative.
REQ-017 In GEN: /C/ with ENABLE_CONFIG=1 -> latch cfg_reg, emit K28.5, tx_even=1, next C_B.
REQ-018 C_B emits D21.5 (C1) or D2.2 (C2); C_C emits cfg_reg[7:0]; C_D emits cfg_reg[15:8] with TX_OSET_indicate=1, then GEN; tx_even alternates 0,1,0.
REQ-019 C1/C2 selection SHALL alternate per /C/ set, starting with C1 after reset; an intervening /I/ set does not reset the alternation.
REQ-020 In GEN: /R/,/S/,/T/,/V/ -> K23.7, K27.7, K29.7, K30.7; /D/ -> encode TXD; illegal code 7 -> K30.7; each is a one-cycle set with TX_OSET_indicate=1, tx_even toggled, stay in GEN.
REQ-021 TX_OSET_indicate SHALL be 0 on K28.5 cycles and on C_B/C_C.
REQ-022 tx_o_set and cfg_reg changes during a multi-cycle set SHALL be ignored until GEN.
REQ-023 tx_disparity SHALL toggle exactly when the emitted group has unequal ones/zeros count.

Reset
REQ-024 During reset: state GEN, tx_code_group=10'h0FA, tx_even=0, TX_OSET_indicate=0, tx_disparity=INIT_RD, C1/C2 selector=C1.
REQ-025 Reset asserted mid-set SHALL abort the set immediately; the first set after release starts from GEN.

Verification
REQ-026 Reset, INIT_RD=0, tx_o_set=0 held -> 0x0FA, 0x245 (I2) repeating; tx_even 1,0; TX_OSET_indicate 0,1; tx_disparity ends negative each pair.
REQ-027 INIT_RD=1, tx_o_set=0 -> first set 0x305, 0x296 (I1), then I2 pairs 0x0FA, 0x245.
REQ-028 Two /C/ sets, cfg_reg=16'h01A0, INIT_RD=0 -> K28.5, D21.5 (0x2AA), D0.5, D1.0 then K28.5, D2.2, D0.5, D1.0 with per-disparity encodings checked against a reference encoder; indicate only on 4th and 8th groups.
REQ-029 /S/, /D/ x4 (TXD 0x55,0x00,0xFF,0xBC), /T/, /R/ -> K27.7, four encoded data, K29.7, K23.7, one cycle each, tx_even alternating, indicate every cycle.
REQ-030 tx_o_set=7 -> K30.7 with current-disparity encoding; ENABLE_CONFIG=0 with /C/ -> idle sequence.
REQ-031 Reset asserted during C_C -> outputs reach reset values asynchronously; after release, /I/ yields 0x0FA first.

Source files
------------

// File: rtl/tx_cg_gen.sv
// tx_cg_gen -- 1000BASE-X transmit code-group generator.
//
// Turns an ordered-set request into a stream of 8b/10b code groups, one per
// GTX_CLK cycle. The block tracks running disparity itself and chooses the
// RD- or RD+ encoding of every group from it.
//
// There is no valid/ready handshake. tx_o_set is sampled only when a new
// ordered set starts (state GEN). A request sampled on edge N drives its first
// code group onto the registered outputs after edge N.
//
// Ports
//   GTX_CLK          in   transmit clock, rising edge
//   mr_main_reset    in   asynchronous active-high reset
//   tx_o_set[2:0]    in   0=/I/ 1=/C/ 2=/R/ 3=/S/ 4=/T/ 5=/V/ 6=/D/ 7=illegal
//   TXD[7:0]         in   data octet for /D/
//   cfg_reg[15:0]    in   configuration word carried by /C/
//   tx_code_group    out  code group, bit 9 = 'a' ... bit 0 = 'j'
//   tx_even          out  even/odd code-group position
//   TX_OSET_indicate out  high on the last group of an ordered set
//   tx_disparity     out  running disparity after this group (1 = positive)
//   state_dbg[2:0]   out  current FSM state (debug visibility)
module tx_cg_gen #(
  parameter logic ENABLE_CONFIG = 1'b1,
  parameter logic INIT_RD       = 1'b0
) (
  input  logic        GTX_CLK,
  input  logic        mr_main_reset,
  input  logic [2:0]  tx_o_set,
  input  logic [7:0]  TXD,
  input  logic [15:0] cfg_reg,
  output logic [9:0]  tx_code_group,
  output logic        tx_even,
  output logic        TX_OSET_indicate,
  output logic        tx_disparity,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    GEN = 3'd0,
    I_B = 3'd1,
    C_B = 3'd2,
    C_C = 3'd3,
    C_D = 3'd4
  } state_t;

  // Special code groups, RD- and RD+ encodings.
  localparam logic [9:0] K28_5_N = 10'b0011111010;
  localparam logic [9:0] K28_5_P = 10'b1100000101;
  localparam logic [9:0] K23_7_N = 10'b1110101000;
  localparam logic [9:0] K23_7_P = 10'b0001010111;
  localparam logic [9:0] K27_7_N = 10'b1101101000;
  localparam logic [9:0] K27_7_P = 10'b0010010111;
  localparam logic [9:0] K29_7_N = 10'b1011101000;
  localparam logic [9:0] K29_7_P = 10'b0100010111;
  localparam logic [9:0] K30_7_N = 10'b0111101000;
  localparam logic [9:0] K30_7_P = 10'b1000010111;

  // Octets used for the second group of /I1/ /I2/ /C1/ /C2/.
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D16_2 = 8'h50;
  localparam logic [7:0] D21_5 = 8'hB5;
  localparam logic [7:0] D2_2  = 8'h42;

  // 5b/6b table, RD- column (abcdei).
  function automatic logic [5:0] six_rdm(input logic [4:0] x);
    case (x)
      5'd0:  six_rdm = 6'b100111;
      5'd1:  six_rdm = 6'b011101;
      5'd2:  six_rdm = 6'b101101;
      5'd3:  six_rdm = 6'b110001;
      5'd4:  six_rdm = 6'b110101;
      5'd5:  six_rdm = 6'b101001;
      5'd6:  six_rdm = 6'b011001;
      5'd7:  six_rdm = 6'b111000;
      5'd8:  six_rdm = 6'b111001;
      5'd9:  six_rdm = 6'b100101;
      5'd10: six_rdm = 6'b010101;
      5'd11: six_rdm = 6'b110100;
      5'd12: six_rdm = 6'b001101;
      5'd13: six_rdm = 6'b101100;
      5'd14: six_rdm = 6'b011100;
      5'd15: six_rdm = 6'b010111;
      5'd16: six_rdm = 6'b011011;
      5'd17: six_rdm = 6'b100011;
      5'd18: six_rdm = 6'b010011;
      5'd19: six_rdm = 6'b110010;
      5'd20: six_rdm = 6'b001011;
      5'd21: six_rdm = 6'b101010;
      5'd22: six_rdm = 6'b011010;
      5'd23: six_rdm = 6'b111010;
      5'd24: six_rdm = 6'b110011;
      5'd25: six_rdm = 6'b100110;
      5'd26: six_rdm = 6'b010110;
      5'd27: six_rdm = 6'b110110;
      5'd28: six_rdm = 6'b001110;
      5'd29: six_rdm = 6'b101110;
      5'd30: six_rdm = 6'b011110;
      default: six_rdm = 6'b101011;
    endcase
  endfunction

  // D.x.y encoder. For an RD+ input, the RD+ sub-block is the complement of
  // the RD- entry whenever that entry is unbalanced. D.7 and D.x.3 are the two
  // balanced exceptions that still differ between the two columns. The 4b
  // column is chosen from the disparity left after the 6b sub-block.
  function automatic logic [9:0] enc_data(input logic [7:0] d, input logic rd);
    logic [5:0] s;
    logic [3:0] f;
    logic       rd1;
    logic       alt;
    s = six_rdm(d[4:0]);
    if (rd && (($countones(s) != 3) || (d[4:0] == 5'd7))) s = ~s;
    rd1 = rd ^ ($countones(s) != 3);
    // A7 avoids a run of five identical bits across the sub-block boundary.
    alt = rd1 ? ((d[4:0] == 5'd11) || (d[4:0] == 5'd13) || (d[4:0] == 5'd14))
              : ((d[4:0] == 5'd17) || (d[4:0] == 5'd18) || (d[4:0] == 5'd20));
    case (d[7:5])
      3'd0: f = 4'b1011;
      3'd1: f = 4'b1001;
      3'd2: f = 4'b0101;
      3'd3: f = 4'b1100;
      3'd4: f = 4'b1101;
      3'd5: f = 4'b1010;
      3'd6: f = 4'b0110;
      default: f = alt ? 4'b0111 : 4'b1110;
    endcase
    if (rd1 && ((d[7:5] == 3'd0) || (d[7:5] == 3'd3) ||
                (d[7:5] == 3'd4) || (d[7:5] == 3'd7))) f = ~f;
    return {s, f};
  endfunction

  state_t      state_q, state_d;
  logic [9:0]  code_q, code_d;
  logic        even_q, even_d;
  logic        ind_q, ind_d;
  logic        rd_q, rd_d;
  logic [15:0] cfg_q, cfg_d;
  logic        csel_q, csel_d;   // 0: next /C/ is C1, 1: C2
  logic        isel_q, isel_d;   // 1: current /I/ is I1, 0: I2

  always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      state_q <= GEN;
      code_q  <= K28_5_N;
      even_q  <= 1'b0;
      ind_q   <= 1'b0;
      rd_q    <= INIT_RD;
      cfg_q   <= 16'h0000;
      csel_q  <= 1'b0;
      isel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      even_q  <= even_d;
      ind_q   <= ind_d;
      rd_q    <= rd_d;
      cfg_q   <= cfg_d;
      csel_q  <= csel_d;
      isel_q  <= isel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    even_d  = even_q;
    ind_d   = 1'b0;
    cfg_d   = cfg_q;
    csel_d  = csel_q;
    isel_d  = isel_q;
    case (state_q)
      GEN: begin
        if ((tx_o_set == 3'd0) || ((tx_o_set == 3'd1) && !ENABLE_CONFIG)) begin
          // I1 pulls a positive disparity back to negative. I2 keeps it negative.
          code_d  = rd_q ? K28_5_P : K28_5_N;
          even_d  = 1'b1;
          isel_d  = rd_q;
          state_d = I_B;
        end else if (tx_o_set == 3'd1) begin
          code_d  = rd_q ? K28_5_P : K28_5_N;
          even_d  = 1'b1;
          cfg_d   = cfg_reg;
          state_d = C_B;
        end else begin
          even_d = ~even_q;
          ind_d  = 1'b1;
          case (tx_o_set)
            3'd2:    code_d = rd_q ? K23_7_P : K23_7_N;
            3'd3:    code_d = rd_q ? K27_7_P : K27_7_N;
            3'd4:    code_d = rd_q ? K29_7_P : K29_7_N;
            3'd6:    code_d = enc_data(TXD, rd_q);
            default: code_d = rd_q ? K30_7_P : K30_7_N;
          endcase
        end
      end
      I_B: begin
        code_d  = enc_data(isel_q ? D5_6 : D16_2, rd_q);
        even_d  = 1'b0;
        ind_d   = 1'b1;
        state_d = GEN;
      end
      C_B: begin
        code_d  = enc_data(csel_q ? D2_2 : D21_5, rd_q);
        even_d  = 1'b0;
        csel_d  = ~csel_q;
        state_d = C_C;
      end
      C_C: begin
        code_d  = enc_data(cfg_q[7:0], rd_q);
        even_d  = 1'b1;
        state_d = C_D;
      end
      C_D: begin
        code_d  = enc_data(cfg_q[15:8], rd_q);
        even_d  = 1'b0;
        ind_d   = 1'b1;
        state_d = GEN;
      end
      default: state_d = GEN;
    endcase
    // Disparity flips only when the group carries an unequal count of ones and zeros.
    rd_d = rd_q ^ ($countones(code_d) != 5);
  end

  assign tx_code_group    = code_q;
  assign tx_even          = even_q;
  assign TX_OSET_indicate = ind_q;
  assign tx_disparity     = rd_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_tx_cg_gen.sv
// Testbench for tx_cg_gen. A reference model predicts every code group when an
// ordered set is requested and pushes it to exp_q. Each cycle pops one entry
// and compares it with the DUT outputs.
// Two auxiliary instances cover INIT_RD=1 and ENABLE_CONFIG=0 with fixed sequences.
module tb_tx_cg_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  oset = 3'd0;
  logic [7:0]  txd = 8'h00;
  logic [15:0] cfg = 16'h0000;
  logic [2:0]  oset_rd1 = 3'd0;
  logic [2:0]  oset_nc  = 3'd1;

  logic [9:0] code, code_r1, code_nc;
  logic       even, ind, rd, even_r1, ind_r1, rd_r1, even_nc, ind_nc, rd_nc;
  logic [2:0] st, st_r1, st_nc;

  tx_cg_gen dut (
    .GTX_CLK(clk), .mr_main_reset(rst), .tx_o_set(oset), .TXD(txd), .cfg_reg(cfg),
    .tx_code_group(code), .tx_even(even), .TX_OSET_indicate(ind),
    .tx_disparity(rd), .state_dbg(st));

  tx_cg_gen #(.ENABLE_CONFIG(1'b1), .INIT_RD(1'b1)) dut_rd1 (
    .GTX_CLK(clk), .mr_main_reset(rst), .tx_o_set(oset_rd1), .TXD(txd), .cfg_reg(cfg),
    .tx_code_group(code_r1), .tx_even(even_r1), .TX_OSET_indicate(ind_r1),
    .tx_disparity(rd_r1), .state_dbg(st_r1));

  tx_cg_gen #(.ENABLE_CONFIG(1'b0), .INIT_RD(1'b0)) dut_nc (
    .GTX_CLK(clk), .mr_main_reset(rst), .tx_o_set(oset_nc), .TXD(txd), .cfg_reg(cfg),
    .tx_code_group(code_nc), .tx_even(even_nc), .TX_OSET_indicate(ind_nc),
    .tx_disparity(rd_nc), .state_dbg(st_nc));

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: {code[9:0], even, indicate, disparity}
  logic [12:0] exp_q[$];
  int n_chk = 0;
  int n_err = 0;

  // model state
  logic m_rd = 1'b0;
  logic m_even = 1'b0;
  logic m_csel = 1'b0;

  function automatic int ones(input logic [9:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 10; i++) n += int'(v[i]);
    return n;
  endfunction

  // Reference D.x.y encoder with explicit RD-/RD+ columns.
  function automatic logic [9:0] ref_d(input logic [7:0] d, input logic r);
    logic [11:0] t6;
    logic [7:0]  t4;
    logic [5:0]  s;
    logic [3:0]  f;
    logic        r1;
    logic [4:0]  x;
    int          c;
    x = d[4:0];
    case (x)
      5'd0:  t6 = {6'b100111, 6'b011000};  5'd1:  t6 = {6'b011101, 6'b100010};
      5'd2:  t6 = {6'b101101, 6'b010010};  5'd3:  t6 = {6'b110001, 6'b110001};
      5'd4:  t6 = {6'b110101, 6'b001010};  5'd5:  t6 = {6'b101001, 6'b101001};
      5'd6:  t6 = {6'b011001, 6'b011001};  5'd7:  t6 = {6'b111000, 6'b000111};
      5'd8:  t6 = {6'b111001, 6'b000110};  5'd9:  t6 = {6'b100101, 6'b100101};
      5'd10: t6 = {6'b010101, 6'b010101};  5'd11: t6 = {6'b110100, 6'b110100};
      5'd12: t6 = {6'b001101, 6'b001101};  5'd13: t6 = {6'b101100, 6'b101100};
      5'd14: t6 = {6'b011100, 6'b011100};  5'd15: t6 = {6'b010111, 6'b101000};
      5'd16: t6 = {6'b011011, 6'b100100};  5'd17: t6 = {6'b100011, 6'b100011};
      5'd18: t6 = {6'b010011, 6'b010011};  5'd19: t6 = {6'b110010, 6'b110010};
      5'd20: t6 = {6'b001011, 6'b001011};  5'd21: t6 = {6'b101010, 6'b101010};
      5'd22: t6 = {6'b011010, 6'b011010};  5'd23: t6 = {6'b111010, 6'b000101};
      5'd24: t6 = {6'b110011, 6'b001100};  5'd25: t6 = {6'b100110, 6'b100110};
      5'd26: t6 = {6'b010110, 6'b010110};  5'd27: t6 = {6'b110110, 6'b001001};
      5'd28: t6 = {6'b001110, 6'b001110};  5'd29: t6 = {6'b101110, 6'b010001};
      5'd30: t6 = {6'b011110, 6'b100001};  default: t6 = {6'b101011, 6'b010100};
    endcase
    s = r ? t6[5:0] : t6[11:6];
    c = 0;
    for (int i = 0; i < 6; i++) c += int'(s[i]);
    r1 = (c == 3) ? r : ~r;
    case (d[7:5])
      3'd0: t4 = {4'b1011, 4'b0100};
      3'd1: t4 = {4'b1001, 4'b1001};
      3'd2: t4 = {4'b0101, 4'b0101};
      3'd3: t4 = {4'b1100, 4'b0011};
      3'd4: t4 = {4'b1101, 4'b0010};
      3'd5: t4 = {4'b1010, 4'b1010};
      3'd6: t4 = {4'b0110, 4'b0110};
      default: begin
        if ((!r1 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
            (r1 && (x == 5'd11 || x == 5'd13 || x == 5'd14)))
          t4 = {4'b0111, 4'b1000};
        else
          t4 = {4'b1110, 4'b0001};
      end
    endcase
    f = r1 ? t4[3:0] : t4[7:4];
    return {s, f};
  endfunction

  function automatic logic [9:0] ref_k(input logic [2:0] o, input logic r);
    case (o)
      3'd2:    return r ? 10'h057 : 10'h3A8;
      3'd3:    return r ? 10'h097 : 10'h368;
      3'd4:    return r ? 10'h117 : 10'h2E8;
      default: return r ? 10'h217 : 10'h1E8;
    endcase
  endfunction

  task automatic push_grp(input logic [9:0] g, input logic e, input logic i);
    if (ones(g) != 5) m_rd = ~m_rd;
    m_even = e;
    exp_q.push_back({g, e, i, m_rd});
  endtask

  task automatic model_set(input logic [2:0] o, input logic [7:0] d, input logic [15:0] c,
                           output int n);
    logic isel;
    case (o)
      3'd0: begin
        isel = m_rd;
        push_grp(m_rd ? 10'h305 : 10'h0FA, 1'b1, 1'b0);
        push_grp(ref_d(isel ? 8'hC5 : 8'h50, m_rd), 1'b0, 1'b1);
        n = 2;
      end
      3'd1: begin
        push_grp(m_rd ? 10'h305 : 10'h0FA, 1'b1, 1'b0);
        push_grp(ref_d(m_csel ? 8'h42 : 8'hB5, m_rd), 1'b0, 1'b0);
        m_csel = ~m_csel;
        push_grp(ref_d(c[7:0], m_rd), 1'b1, 1'b0);
        push_grp(ref_d(c[15:8], m_rd), 1'b0, 1'b1);
        n = 4;
      end
      3'd6: begin
        push_grp(ref_d(d, m_rd), ~m_even, 1'b1);
        n = 1;
      end
      default: begin
        push_grp(ref_k(o, m_rd), ~m_even, 1'b1);
        n = 1;
      end
    endcase
  endtask

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample #1 after the edge and compare with the oldest expectation.
  task automatic step(input string tag);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_err++;
      $error("FAIL %s observed=group expected=none_queued", tag);
    end else begin
      check(tag, {code, even, ind, rd}, exp_q.pop_front());
    end
  endtask

  task automatic scramble();
    oset = 3'($urandom_range(0, 7));
    txd  = 8'($urandom);
    cfg  = 16'($urandom);
  endtask

  // Drives one request. Inputs change while the set is running and must be ignored.
  task automatic do_set(input string tag, input logic [2:0] o, input logic [7:0] d,
                        input logic [15:0] c);
    int n;
    oset = o; txd = d; cfg = c;
    model_set(o, d, c, n);
    for (int i = 0; i < n; i++) begin
      step(tag);
      if (i < n - 1) scramble();
    end
  endtask

  task automatic model_reset();
    m_rd = 1'b0; m_even = 1'b0; m_csel = 1'b0;
    exp_q.delete();
  endtask

  logic [12:0] r1_exp [0:3];
  logic [12:0] nc_exp [0:3];

  initial begin
    int n;
    r1_exp[0] = {10'h305, 3'b100}; r1_exp[1] = {10'h296, 3'b010};
    r1_exp[2] = {10'h0FA, 3'b101}; r1_exp[3] = {10'h245, 3'b010};
    nc_exp[0] = {10'h0FA, 3'b101}; nc_exp[1] = {10'h245, 3'b010};
    nc_exp[2] = {10'h0FA, 3'b101}; nc_exp[3] = {10'h245, 3'b010};

    // reset state
    #12;
    check("rst_main", {code, even, ind, rd}, {10'h0FA, 3'b000});
    check("rst_state", {10'd0, st}, 13'd0);
    check("rst_rd1", {code_r1, even_r1, ind_r1, rd_r1}, {10'h0FA, 3'b001});
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // idle from RD-, with INIT_RD=1 and ENABLE_CONFIG=0 instances alongside
    oset = 3'd0;
    model_set(3'd0, 8'h00, 16'h0000, n);
    model_set(3'd0, 8'h00, 16'h0000, n);
    for (int i = 0; i < 4; i++) begin
      step("idle");
      check("idle_init_rd1", {code_r1, even_r1, ind_r1, rd_r1}, r1_exp[i]);
      check("idle_no_cfg", {code_nc, even_nc, ind_nc, rd_nc}, nc_exp[i]);
    end

    // first /C/ set is C1 (D21.5 after K28.5 RD-)
    oset = 3'd1; cfg = 16'h01A0;
    model_set(3'd1, 8'h00, 16'h01A0, n);
    step("cfg1_k");
    scramble();
    step("cfg1_b");
    check("cfg1_d21_5", {3'd0, code}, {3'd0, 10'h2AA});
    scramble();
    step("cfg1_c");
    scramble();
    step("cfg1_d");
    do_set("cfg2", 3'd1, 8'h00, 16'h01A0);
    do_set("cfg3", 3'd1, 8'h00, 16'h01A0);
    do_set("idle_mid", 3'd0, 8'h00, 16'h0000);
    do_set("cfg4", 3'd1, 8'h00, 16'hBEEF);

    // single-cycle ordered sets
    do_set("set_s", 3'd3, 8'h00, 16'h0000);
    do_set("data_55", 3'd6, 8'h55, 16'h0000);
    do_set("data_00", 3'd6, 8'h00, 16'h0000);
    do_set("data_ff", 3'd6, 8'hFF, 16'h0000);
    do_set("data_bc", 3'd6, 8'hBC, 16'h0000);
    do_set("set_t", 3'd4, 8'h00, 16'h0000);
    do_set("set_r", 3'd2, 8'h00, 16'h0000);
    do_set("set_v", 3'd5, 8'h00, 16'h0000);
    do_set("illegal", 3'd7, 8'h00, 16'h0000);
    do_set("data_f1", 3'd6, 8'hF1, 16'h0000);
    do_set("illegal2", 3'd7, 8'h00, 16'h0000);

    // mixed random traffic
    for (int k = 0; k < 40; k++)
      do_set("rand", 3'($urandom_range(0, 7)), 8'($urandom), 16'($urandom));

    // reset in the middle of a /C/ set
    oset = 3'd1; cfg = 16'h1234;
    model_set(3'd1, 8'h00, 16'h1234, n);
    step("abort_k");
    step("abort_b");
    #1 rst = 1'b1;
    #1;
    check("async_rst", {code, even, ind, rd}, {10'h0FA, 3'b000});
    check("async_rst_state", {10'd0, st}, 13'd0);
    @(posedge clk);
    #1;
    check("rst_hold", {code, even, ind, rd}, {10'h0FA, 3'b000});
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    oset = 3'd0;
    model_set(3'd0, 8'h00, 16'h0000, n);
    step("post_rst_k");
    check("post_rst_first", {3'd0, code}, {3'd0, 10'h0FA});
    step("post_rst_i");
    do_set("post_rst_cfg", 3'd1, 8'h00, 16'h5AC3);
    do_set("post_rst_d", 3'd6, 8'hAA, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
